comb_result_buffer: RTL and testbench
=====================================

Name: comb_result_buffer

Overview:
Row-serving buffer that feeds the argmax stage. It collects the final combination matrix (adjacency x feature x weight) as a serial, row-major element stream from the combination unit, accumulating over one or more partial-sum passes. When the matrix is complete it asserts done_comb and serves whole rows, zero-latency, at the row index presented by the argmax stage. It releases the matrix when the argmax stage reports done.

Parameters:
FINAL_MATRIX_ROW, 6, number of matrix rows (nodes)
FINAL_MATRIX_COL, 3, number of matrix columns (classes)
ROW_WIDTH, $clog2(FINAL_MATRIX_ROW+1), width of read_row; must encode the value FINAL_MATRIX_ROW
COL_WIDTH, $clog2(FINAL_MATRIX_COL), internal column counter width
DOT_PROD_WIDTH, 16, element width, unsigned
NUM_PASSES, 1, partial-sum passes per matrix; must be >= 1

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; clears counters and begins a fill
wr_valid  input  1  wr_data valid
wr_ready  output  1  buffer accepts an element this cycle
wr_data  input  DOT_PROD_WIDTH  next element, row-major order
read_row  input  ROW_WIDTH  row index requested by the argmax stage
adj_fm_wm_out  output  DOT_PROD_WIDTH x FINAL_MATRIX_COL (unpacked [0:FINAL_MATRIX_COL-1])  row data at read_row
done_comb  output  1  matrix complete and being served
consumer_done  input  1  argmax stage finished; releases the buffer
busy  output  1  high in FILL or SERVE

Behaviour:
- Reset (async): state=IDLE; row_cnt, col_cnt, pass_cnt = 0; done_comb=0; wr_ready=0; busy=0. Memory contents are not cleared.
- adj_fm_wm_out is forced to all-zero unless state=SERVE.
- States: IDLE, FILL, SERVE.
- IDLE:
  - wr_ready=0.
  - start moves to FILL and clears all counters.
- FILL:
  - wr_ready=1.
  - A handshake is wr_valid&wr_ready at a rising edge.
  - On each handshake, mem[row_cnt][col_cnt] is written: overwrite when pass_cnt==0, else mem += wr_data.
  - Accumulate addition is modulo 2^DOT_PROD_WIDTH.
  - col_cnt increments; at FINAL_MATRIX_COL-1 it wraps to 0 and row_cnt increments.
  - At the last element of a pass (row FINAL_MATRIX_ROW-1, col FINAL_MATRIX_COL-1), row_cnt and col_cnt wrap to 0 and pass_cnt increments.
  - If that pass was pass NUM_PASSES-1, next state=SERVE.
  - wr_valid low stalls the counters; there is no timeout.
- SERVE:
  - done_comb=1, registered; it rises the cycle after the final handshake edge.
  - wr_ready=0.
  - adj_fm_wm_out[j] = mem[read_row][j], purely combinational from read_row (zero latency), so the consumer samples the same cycle.
  - read_row >= FINAL_MATRIX_ROW returns all zeros; the consumer's terminal count equals FINAL_MATRIX_ROW.
  - consumer_done moves to IDLE; done_comb falls on the next edge.
- Simultaneous events:
  - start has priority over everything except reset.
  - start in FILL restarts the fill at pass 0, element 0; a handshake in that same cycle is discarded.
  - start in SERVE goes directly to FILL and drops done_comb next edge.
  - start together with consumer_done in SERVE: go to FILL.
- reset mid-FILL or mid-SERVE aborts immediately; partial data is discarded, and the next fill overwrites it on pass 0.
- busy = (state != IDLE).

Optional Feature:
Macro: COMB_RESULT_SATURATE_EN.
- Defined: the accumulate is unsigned saturating; a sum exceeding 2^DOT_PROD_WIDTH-1 stores all-ones.
- Undefined: the accumulate wraps modulo 2^DOT_PROD_WIDTH.
- Pass-0 overwrite is identical in both builds.

Test Plan:
- NUM_PASSES=1:
  - Stimulus: start, then stream 18 elements, values 1..18, wr_valid held high.
  - Response: done_comb rises on the cycle after the 18th handshake.
  - Reads: read_row=0 gives {1,2,3}; read_row=5 gives {16,17,18}; read_row=6 gives {0,0,0}.
- Backpressure gaps: wr_valid toggled 1,0,0,1 across the stream.
  - Counters advance only on handshakes.
  - done_comb rises only after exactly 18 handshakes; contents match the no-gap run.
- NUM_PASSES=2:
  - Stimulus: pass 0 all elements 5, then pass 1 all elements 7.
  - Response: every element reads 12.
  - Overflow: element (0,0) pass 0=0xFFF0, pass 1=0x0020 reads 0x0010; with COMB_RESULT_SATURATE_EN it reads 0xFFFF.
- Release and restart:
  - consumer_done pulse in SERVE: done_comb=0 and adj_fm_wm_out=0 next cycle, busy=0.
  - A new start and fill of all 9s reads 9 everywhere; no stale accumulate.
- start after 10 handshakes in FILL: counters restart.
  - 18 new elements of value 2 then give done_comb=1 and all rows {2,2,2}.
  - A handshake coincident with start is ignored.
- Async reset asserted mid-FILL (element 7) and mid-SERVE: all outputs return to zero immediately, state=IDLE; the next start and fill complete normally.

Source files
------------

// File: rtl/comb_result_buffer.sv
// ---------------------------------------------------------------------------
// comb_result_buffer
//
// Row-serving buffer between the combination unit and the argmax stage.
// Collects the final (adjacency x feature x weight) matrix as a row-major
// element stream. It accumulates over NUM_PASSES partial-sum passes. Once
// complete it serves whole rows combinationally at read_row. The argmax stage
// releases the buffer with consumer_done.
//
// Optional feature macro: COMB_RESULT_SATURATE_EN
//   defined   -> partial-sum accumulate saturates at all-ones
//   undefined -> partial-sum accumulate wraps modulo 2^DOT_PROD_WIDTH
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   start          single-cycle pulse: clear counters, begin a fill
//   wr_valid       wr_data valid
//   wr_ready       buffer accepts an element this cycle (high in FILL)
//   wr_data        next matrix element, row-major
//   read_row       row requested by the argmax stage
//   adj_fm_wm_out  row data at read_row (zero outside SERVE / out of range)
//   done_comb      matrix complete and being served
//   consumer_done  argmax stage finished; releases the buffer
//   busy           high in FILL or SERVE
// ---------------------------------------------------------------------------
module comb_result_buffer #(
    parameter int FINAL_MATRIX_ROW = 6,
    parameter int FINAL_MATRIX_COL = 3,
    parameter int ROW_WIDTH        = $clog2(FINAL_MATRIX_ROW + 1),
    parameter int COL_WIDTH        = $clog2(FINAL_MATRIX_COL),
    parameter int DOT_PROD_WIDTH   = 16,
    parameter int NUM_PASSES       = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DOT_PROD_WIDTH-1:0] wr_data,
    input  logic [ROW_WIDTH-1:0]      read_row,
    output logic [DOT_PROD_WIDTH-1:0] adj_fm_wm_out [0:FINAL_MATRIX_COL-1],
    output logic                      done_comb,
    input  logic                      consumer_done,
    output logic                      busy
);

    // A single-column matrix would give a zero-width column counter.
    localparam int CW = (COL_WIDTH < 1) ? 1 : COL_WIDTH;
    localparam int PW = $clog2(NUM_PASSES + 1);

    localparam logic [ROW_WIDTH-1:0] LAST_ROW  = ROW_WIDTH'(FINAL_MATRIX_ROW - 1);
    localparam logic [ROW_WIDTH-1:0] NUM_ROWS  = ROW_WIDTH'(FINAL_MATRIX_ROW);
    localparam logic [CW-1:0]        LAST_COL  = CW'(FINAL_MATRIX_COL - 1);
    localparam logic [PW-1:0]        LAST_PASS = PW'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [ROW_WIDTH-1:0]    row_cnt_reg, row_cnt_next;
    logic [CW-1:0]           col_cnt_reg, col_cnt_next;
    logic [PW-1:0]           pass_cnt_reg, pass_cnt_next;
    logic                    done_comb_reg;
    logic                    mem_we;
    logic [DOT_PROD_WIDTH-1:0] mem_cur;
    logic [DOT_PROD_WIDTH-1:0] mem_acc;
    logic [DOT_PROD_WIDTH-1:0] mem_wdata;

    // Matrix storage. Rows must be readable with zero latency, so the read
    // port is asynchronous; contents are intentionally not reset.
    logic [DOT_PROD_WIDTH-1:0] mem [0:FINAL_MATRIX_ROW-1][0:FINAL_MATRIX_COL-1];

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        row_cnt_next  = row_cnt_reg;
        col_cnt_next  = col_cnt_reg;
        pass_cnt_next = pass_cnt_reg;
        mem_we        = 1'b0;

        case (state_reg)
            IDLE: begin
            end
            FILL: begin
                if (wr_valid) begin
                    mem_we = 1'b1;
                    if (col_cnt_reg == LAST_COL) begin
                        col_cnt_next = '0;
                        if (row_cnt_reg == LAST_ROW) begin
                            row_cnt_next  = '0;
                            pass_cnt_next = pass_cnt_reg + 1'b1;
                            if (pass_cnt_reg == LAST_PASS) begin
                                state_next = SERVE;
                            end
                        end else begin
                            row_cnt_next = row_cnt_reg + 1'b1;
                        end
                    end else begin
                        col_cnt_next = col_cnt_reg + 1'b1;
                    end
                end
            end
            SERVE: begin
                if (consumer_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // start overrides everything, including a handshake in the same
        // cycle, which is dropped rather than written.
        if (start) begin
            state_next    = FILL;
            row_cnt_next  = '0;
            col_cnt_next  = '0;
            pass_cnt_next = '0;
            mem_we        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            row_cnt_reg   <= '0;
            col_cnt_reg   <= '0;
            pass_cnt_reg  <= '0;
            done_comb_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            row_cnt_reg   <= row_cnt_next;
            col_cnt_reg   <= col_cnt_next;
            pass_cnt_reg  <= pass_cnt_next;
            done_comb_reg <= (state_next == SERVE);
        end
    end

    // ------------------------------------------------------------------
    // Write datapath: pass 0 overwrites, later passes accumulate
    // ------------------------------------------------------------------
    assign mem_cur = mem[row_cnt_reg][col_cnt_reg];

`ifdef COMB_RESULT_SATURATE_EN
    logic [DOT_PROD_WIDTH:0] mem_sum;
    assign mem_sum = {1'b0, mem_cur} + {1'b0, wr_data};
    assign mem_acc = mem_sum[DOT_PROD_WIDTH] ? '1 : mem_sum[DOT_PROD_WIDTH-1:0];
`else
    assign mem_acc = mem_cur + wr_data;
`endif

    assign mem_wdata = (pass_cnt_reg == '0) ? wr_data : mem_acc;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[row_cnt_reg][col_cnt_reg] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Row read port
    // ------------------------------------------------------------------
    logic                 row_valid;
    logic [ROW_WIDTH-1:0] rd_row;

    // Out-of-range rows (the consumer's terminal count) read as zero; the
    // clamp keeps the array index in bounds.
    assign row_valid = (state_reg == SERVE) && (read_row < NUM_ROWS);
    assign rd_row    = (read_row < NUM_ROWS) ? read_row : '0;

    generate
        for (genvar gi = 0; gi < FINAL_MATRIX_COL; gi++) begin : g_col
            assign adj_fm_wm_out[gi] = row_valid ? mem[rd_row][gi] : '0;
        end
    endgenerate

    assign wr_ready  = (state_reg == FILL);
    assign busy      = (state_reg != IDLE);
    assign done_comb = done_comb_reg;

endmodule

// File: tb/tb_comb_result_buffer.sv
module tb_comb_result_buffer;

    localparam int R  = 6;
    localparam int C  = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start1 = 1'b0;
    logic          start2 = 1'b0;
    logic          wr_valid = 1'b0;
    logic          consumer_done = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [2:0]    read_row = '0;
    logic          wr_ready1, wr_ready2, done1, done2, busy1, busy2;
    logic [DW-1:0] out1 [0:C-1];
    logic [DW-1:0] out2 [0:C-1];

    always #5 clk = ~clk;

    // Single-pass instance
    comb_result_buffer #(.NUM_PASSES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .wr_valid(wr_valid),
        .wr_ready(wr_ready1), .wr_data(wr_data), .read_row(read_row),
        .adj_fm_wm_out(out1), .done_comb(done1),
        .consumer_done(consumer_done), .busy(busy1)
    );

    // Two-pass instance
    comb_result_buffer #(.NUM_PASSES(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .wr_valid(wr_valid),
        .wr_ready(wr_ready2), .wr_data(wr_data), .read_row(read_row),
        .adj_fm_wm_out(out2), .done_comb(done2),
        .consumer_done(consumer_done), .busy(busy2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 1;

    // Reference model: expected matrix plus accepted-element count.
    logic [DW-1:0] m_mem [0:R-1][0:C-1];
    int            m_cnt   = 0;
    int            m_np    = 1;
    bit            m_serve = 1'b0;

    typedef struct {
        logic [2:0]    row;
        logic [DW-1:0] e0, e1, e2;
    } rd_vec_t;
    rd_vec_t rd_tab [0:3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic cur_done();
        return (sel == 1) ? done1 : done2;
    endfunction
    function automatic logic cur_busy();
        return (sel == 1) ? busy1 : busy2;
    endfunction
    function automatic logic cur_ready();
        return (sel == 1) ? wr_ready1 : wr_ready2;
    endfunction
    function automatic logic [DW-1:0] cur_out(input int c);
        return (sel == 1) ? out1[c] : out2[c];
    endfunction

    function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int s;
        s = int'(a) + int'(b);
`ifdef COMB_RESULT_SATURATE_EN
        if (s > 65535) return 16'hFFFF;
`endif
        return DW'(s % 65536);
    endfunction

    task automatic model_accept(input logic [DW-1:0] v);
        int k, p;
        k = m_cnt % (R * C);
        p = m_cnt / (R * C);
        if (p == 0) m_mem[k / C][k % C] = v;
        else        m_mem[k / C][k % C] = model_add(m_mem[k / C][k % C], v);
        m_cnt++;
        if (m_cnt == R * C * m_np) m_serve = 1'b1;
    endtask

    // Start pulse, optionally with a coincident handshake and/or consumer_done.
    task automatic do_start(input bit with_hs, input logic [DW-1:0] v, input bit with_cd);
        @(negedge clk);
        if (sel == 1) start1 = 1'b1; else start2 = 1'b1;
        wr_valid = with_hs;
        wr_data = v;
        consumer_done = with_cd;
        @(posedge clk);
        #1;
        start1 = 1'b0; start2 = 1'b0; wr_valid = 1'b0; consumer_done = 1'b0;
        m_cnt = 0;
        m_serve = 1'b0;
        chk("start busy", 32'(cur_busy()), 32'd1);
        chk("start wr_ready", 32'(cur_ready()), 32'd1);
        chk("start done_comb", 32'(cur_done()), 32'd0);
        $display("start dut%0d hs=%0d cd=%0d", sel, with_hs, with_cd);
    endtask

    // One element, preceded by 'gaps' idle cycles of garbage with wr_valid low.
    task automatic send(input logic [DW-1:0] v, input int gaps);
        repeat (gaps) begin
            @(negedge clk);
            wr_valid = 1'b0;
            wr_data = DW'($urandom);
        end
        @(negedge clk);
        chk("fill wr_ready", 32'(cur_ready()), 32'd1);
        chk("gap done_comb", 32'(cur_done()), 32'd0);
        wr_valid = 1'b1;
        wr_data = v;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        model_accept(v);
        chk("hs done_comb", 32'(cur_done()), 32'(m_serve));
        chk("hs wr_ready", 32'(cur_ready()), 32'(!m_serve));
    endtask

    task automatic fill_rand(input int max_gap);
        for (int i = 0; i < R * C * m_np; i++) send(DW'($urandom), $urandom_range(max_gap, 0));
    endtask

    task automatic check_rows(input string name);
        logic [DW-1:0] e;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            read_row = 3'(r);
            #1;
            for (int c = 0; c < C; c++) begin
                e = (m_serve && r < R) ? m_mem[r][c] : '0;
                chk($sformatf("%s row%0d col%0d", name, r, c), 32'(cur_out(c)), 32'(e));
            end
            $display("read dut%0d row %0d: %h %h %h", sel, r, cur_out(0), cur_out(1), cur_out(2));
        end
    endtask

    task automatic release_buf();
        @(negedge clk);
        read_row = 3'd0;
        consumer_done = 1'b1;
        @(posedge clk);
        #1;
        consumer_done = 1'b0;
        m_serve = 1'b0;
        chk("release done_comb", 32'(cur_done()), 32'd0);
        chk("release busy", 32'(cur_busy()), 32'd0);
        chk("release wr_ready", 32'(cur_ready()), 32'd0);
        for (int c = 0; c < C; c++) chk("release out", 32'(cur_out(c)), 32'd0);
        $display("release dut%0d", sel);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        m_cnt = 0;
        m_serve = 1'b0;
        chk("areset done_comb", 32'(cur_done()), 32'd0);
        chk("areset busy", 32'(cur_busy()), 32'd0);
        chk("areset wr_ready", 32'(cur_ready()), 32'd0);
        for (int c = 0; c < C; c++) chk("areset out", 32'(cur_out(c)), 32'd0);
        $display("async reset dut%0d", sel);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_const(input string name, input logic [DW-1:0] v);
        for (int r = 0; r < R; r++) begin
            @(negedge clk);
            read_row = 3'(r);
            #1;
            for (int c = 0; c < C; c++) chk(name, 32'(cur_out(c)), 32'(v));
        end
    endtask

    initial begin
        rd_tab[0] = '{row: 3'd0, e0: 16'd1,  e1: 16'd2,  e2: 16'd3};
        rd_tab[1] = '{row: 3'd5, e0: 16'd16, e1: 16'd17, e2: 16'd18};
        rd_tab[2] = '{row: 3'd6, e0: 16'd0,  e1: 16'd0,  e2: 16'd0};
        rd_tab[3] = '{row: 3'd2, e0: 16'd7,  e1: 16'd8,  e2: 16'd9};

        // Reset state
        #2;
        chk("rst done1", 32'(done1), 32'd0);
        chk("rst busy1", 32'(busy1), 32'd0);
        chk("rst ready1", 32'(wr_ready1), 32'd0);
        chk("rst done2", 32'(done2), 32'd0);
        chk("rst busy2", 32'(busy2), 32'd0);
        for (int c = 0; c < C; c++) chk("rst out1", 32'(out1[c]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- single-pass instance ----------------
        sel = 1; m_np = 1;

        // Contiguous stream 1..18, then table-driven reads
        do_start(1'b0, '0, 1'b0);
        for (int i = 0; i < R * C; i++) send(DW'(i + 1), 0);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            read_row = rd_tab[t].row;
            #1;
            chk("tab e0", 32'(out1[0]), 32'(rd_tab[t].e0));
            chk("tab e1", 32'(out1[1]), 32'(rd_tab[t].e1));
            chk("tab e2", 32'(out1[2]), 32'(rd_tab[t].e2));
            $display("table row %0d: %h %h %h", rd_tab[t].row, out1[0], out1[1], out1[2]);
        end
        release_buf();

        // Backpressure: valid pattern 1,0,0,1 repeating
        do_start(1'b0, '0, 1'b0);
        for (int i = 0; i < R * C; i++) send(DW'(i + 1), (i % 2 == 1) ? 2 : 0);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            read_row = rd_tab[t].row;
            #1;
            chk("gap tab e0", 32'(out1[0]), 32'(rd_tab[t].e0));
            chk("gap tab e2", 32'(out1[2]), 32'(rd_tab[t].e2));
        end
        check_rows("gap");
        release_buf();

        // Restart with all 9s
        do_start(1'b0, '0, 1'b0);
        for (int i = 0; i < R * C; i++) send(16'd9, 0);
        check_const("nines", 16'd9);
        release_buf();

        // start after 10 handshakes, with a coincident (discarded) handshake
        do_start(1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) send(DW'($urandom), 0);
        do_start(1'b1, 16'hAAAA, 1'b0);
        for (int i = 0; i < R * C; i++) send(16'd2, 0);
        check_const("restart twos", 16'd2);

        // start in SERVE, then start together with consumer_done in SERVE
        do_start(1'b0, '0, 1'b0);
        fill_rand(2);
        check_rows("serve restart");
        do_start(1'b0, '0, 1'b1);
        fill_rand(1);
        check_rows("start+cd");
        release_buf();

        // Async reset mid-FILL (after element 7) and mid-SERVE
        do_start(1'b0, '0, 1'b0);
        for (int i = 0; i < 7; i++) send(DW'($urandom), 0);
        async_reset();
        do_start(1'b0, '0, 1'b0);
        fill_rand(2);
        check_rows("after fill reset");
        async_reset();
        do_start(1'b0, '0, 1'b0);
        fill_rand(0);
        check_rows("after serve reset");
        release_buf();

        // ---------------- two-pass instance ----------------
        sel = 2; m_np = 2;

        do_start(1'b0, '0, 1'b0);
        for (int i = 0; i < R * C; i++) send(16'd5, 0);
        for (int i = 0; i < R * C; i++) send(16'd7, 0);
        check_const("two pass", 16'd12);
        release_buf();

        // Overflow on element (0,0)
        do_start(1'b0, '0, 1'b0);
        send(16'hFFF0, 0);
        for (int i = 1; i < R * C; i++) send(DW'($urandom), 0);
        send(16'h0020, 0);
        for (int i = 1; i < R * C; i++) send(DW'($urandom), 1);
        @(negedge clk);
        read_row = 3'd0;
        #1;
`ifdef COMB_RESULT_SATURATE_EN
        chk("overflow (0,0)", 32'(out2[0]), 32'h0000FFFF);
`else
        chk("overflow (0,0)", 32'(out2[0]), 32'h00000010);
`endif
        check_rows("overflow");
        release_buf();

        // All 9s after an accumulate run: pass 0 must overwrite stale data
        do_start(1'b0, '0, 1'b0);
        for (int i = 0; i < R * C; i++) send(16'd9, 0);
        for (int i = 0; i < R * C; i++) send(16'd0, 0);
        check_const("two pass nines", 16'd9);
        release_buf();

        // Random two-pass run with gaps
        do_start(1'b0, '0, 1'b0);
        fill_rand(2);
        check_rows("two pass rand");
        release_buf();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
